serial_add_ctrl: RTL and testbench
==================================

# serial_add_ctrl

Bit-serial multi-bit adder controller built around the team's one-bit full-adder cell `count`. It loads two WIDTH-bit operands and a carry-in, then streams one operand bit pair per clock, LSB first, through a single `count` instance. A carry flip-flop closes the loop between bit slices, and the sum bits are shifted into a result register. The block sits directly upstream of the full-adder cell, feeds it, and consumes its `sum`/`cout` each cycle. It presents a start/busy/done interface to the surrounding datapath.

## Interface
- WIDTH, 8, operand and result width in bits; legal range ≥ 1.
- clk  input  1  rising-edge clock; single clock domain.
- rst_n  input  1  reset, asynchronous assert, active-low; clears all state.
- start  input  1  request; sampled only in IDLE or DONE.
- a  input  WIDTH  operand A; captured on the accepting edge.
- b  input  WIDTH  operand B; captured on the accepting edge.
- cin  input  1  carry-in; captured on the accepting edge.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; the result is complete.
- sum  output  WIDTH  registered result; holds the last completed sum.
- cout  output  1  registered carry-out of the last completed addition.

## Operation
- Internal state:
  - Shift registers `ra`, `rb` (WIDTH bits each).
  - Carry flip-flop `c`.
  - Partial-result register `rs` (WIDTH bits).
  - Bit counter, $clog2(WIDTH+1) bits wide.
  - FSM {IDLE, RUN, DONE}.
- `count` instance inputs: a=ra[0], b=rb[0], cin=c.
- IDLE: on start=1, load ra=a, rb=b, c=cin, counter=0, then go to RUN.
- RUN, every edge:
  - rs <= {fa_sum, rs[WIDTH-1:1]}.
  - c <= fa_cout.
  - ra and rb shift right by one, zero-filled.
  - counter++.
- RUN exit: on the edge where counter == WIDTH-1, also load sum <= {fa_sum, rs[WIDTH-1:1]} and cout <= fa_cout, then go to DONE.
- DONE: done=1 for exactly this cycle.
  - start=1: behaves as in IDLE (reload, go to RUN).
  - Otherwise: go to IDLE.
- start while in RUN: ignored. Operands are not re-sampled, and nothing is queued.
- a, b and cin are don't-care except on an accepting edge.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1). It must match the WIDTH+1-bit reference sum exactly.
- sum and cout change only on the final RUN edge. They never show partial results.
- Reset (async, rst_n=0): FSM to IDLE; busy=0, done=0, sum=0, cout=0; all internal registers 0.
  - Reset mid-RUN aborts the operation. No done pulse follows, and sum/cout read 0.
- WIDTH=1: RUN lasts one cycle, and the exit edge is the first RUN edge.

## Timing
- Accepting edge E0 (start=1 in IDLE or DONE): busy=1 from E0 to E(WIDTH).
- Bit i is processed on edge E(i+1), for i = 0..WIDTH-1.
- sum, cout and done become valid after E(WIDTH). done drops after E(WIDTH+1).
- Latency from the accepting edge to done: WIDTH cycles.
- Throughput: back-to-back start during DONE gives one result per WIDTH+1 cycles. done and busy are never both high.
- No combinational path from inputs to outputs. All outputs come straight from flops.

## Test plan
- WIDTH=8; a=0x5A, b=0x33, cin=0, start for one cycle:
  - busy high for 8 cycles.
  - done pulses 8 cycles after the accepting edge.
  - sum=0x8D, cout=0.
- a=0xFF, b=0x01, cin=0: full carry ripple; sum=0x00, cout=1.
- a=0xFF, b=0xFF, cin=1: sum=0xFF, cout=1. Then a=0, b=0, cin=0: sum=0x00, cout=0. The carry must not leak between operations.
- Start 0x10+0x20, then pulse start with a=0xAA, b=0x55 on RUN cycle 3:
  - Ignored; result sum=0x30, cout=0.
  - Exactly one done pulse.
- Start 0x7F+0x01, then assert rst_n=0 on RUN cycle 4:
  - Outputs go to 0 immediately, with no done pulse.
  - After release, start 0x01+0x01 gives sum=0x02 at done.
- Hold start=1 continuously with a=0x0F, b=0x01:
  - done pulses every 9 cycles.
  - Each result is sum=0x10, cout=0.
  - busy is low only on done cycles.

Source files
------------

// File: rtl/serial_add_ctrl_if.sv
// Start/busy/done operand bus between the surrounding datapath and the
// bit-serial adder controller.
interface serial_add_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder: streams operand bits LSB first through one
// full-adder cell, closing the carry loop with a flip-flop.
module count (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    serial_add_ctrl_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] ra_q, ra_d;
    logic [WIDTH-1:0] rb_q, rb_d;
    logic [WIDTH-1:0] rs_q, rs_d;
    logic             c_q, c_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             fa_sum_s;
    logic             fa_cout_s;
    logic [WIDTH-1:0] rs_shift_s;

    count u_fa (
        .a    (ra_q[0]),
        .b    (rb_q[0]),
        .cin  (c_q),
        .sum  (fa_sum_s),
        .cout (fa_cout_s)
    );

    // A one-bit result register has nothing to shift down, only the new bit.
    generate
        if (WIDTH == 1) begin : g_rs_one
            assign rs_shift_s = fa_sum_s;
        end else begin : g_rs_multi
            assign rs_shift_s = {fa_sum_s, rs_q[WIDTH-1:1]};
        end
    endgenerate

    // State and datapath registers; reset mid-operation discards everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ra_q    <= {WIDTH{1'b0}};
            rb_q    <= {WIDTH{1'b0}};
            rs_q    <= {WIDTH{1'b0}};
            c_q     <= 1'b0;
            cnt_q   <= {CW{1'b0}};
            sum_q   <= {WIDTH{1'b0}};
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            rs_q    <= rs_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic; busy/done are decoded from the next state so they leave flops.
    always_comb begin
        state_d = state_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        rs_d    = rs_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    ra_d    = bus.a;
                    rb_d    = bus.b;
                    c_d     = bus.cin;
                    cnt_d   = {CW{1'b0}};
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                rs_d  = rs_shift_s;
                c_d   = fa_cout_s;
                ra_d  = ra_q >> 1;
                rb_d  = rb_q >> 1;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_CNT) begin
                    sum_d   = rs_shift_s;
                    cout_d  = fa_cout_s;
                    state_d = DONE;
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl (WIDTH=8) with hand-computed results.
module tb_serial_add_ctrl;
    localparam int WIDTH = 8;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_pass;
    int   n_fail;

    serial_add_ctrl_if #(.WIDTH(WIDTH)) bus ();

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One start pulse; measures latency and busy length, checks result.
    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic ci, input logic [7:0] exp_sum, input logic exp_cout);
        int lat;
        int nbusy;
        lat   = 0;
        nbusy = 0;
        bus.start = 1'b1;
        bus.a = a;
        bus.b = b;
        bus.cin = ci;
        tick();
        bus.start = 1'b0;
        bus.a = 8'h00;
        bus.b = 8'h00;
        bus.cin = 1'b0;
        if (bus.busy === 1'b1) nbusy++;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (bus.busy === 1'b1) nbusy++;
            if (bus.done === 1'b1) begin
                lat = i;
                break;
            end
        end
        chk({tag, "_latency"}, lat, 32'd8);
        chk({tag, "_busy_cycles"}, nbusy, 32'd8);
        chk({tag, "_sum"}, {24'd0, bus.sum}, {24'd0, exp_sum});
        chk({tag, "_cout"}, {31'd0, bus.cout}, {31'd0, exp_cout});
        chk({tag, "_busy_at_done"}, {31'd0, bus.busy}, 32'd0);
        tick();
        chk({tag, "_done_drop"}, {31'd0, bus.done}, 32'd0);
    endtask

    initial begin
        int ndone;
        int last_done;
        int ndone_run;
        logic [7:0] seen_sum;
        n_chk  = 0;
        n_pass = 0;
        n_fail = 0;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.a = 8'h00;
        bus.b = 8'h00;
        bus.cin = 1'b0;
        repeat (2) tick();
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_sum", {24'd0, bus.sum}, 32'd0);
        chk("rst_cout", {31'd0, bus.cout}, 32'd0);
        rst_n = 1'b1;
        tick();

        run_op("add_5a_33", 8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0);
        run_op("ripple_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        run_op("max_ff_ff_1", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
        run_op("zero_after_max", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);

        // start pulsed with new operands on RUN cycle 3 must be ignored
        bus.start = 1'b1;
        bus.a = 8'h10;
        bus.b = 8'h20;
        bus.cin = 1'b0;
        tick();
        bus.start = 1'b0;
        ndone = 0;
        seen_sum = 8'h00;
        for (int i = 1; i <= 15; i++) begin
            if (i == 3) begin
                bus.start = 1'b1;
                bus.a = 8'hAA;
                bus.b = 8'h55;
                bus.cin = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            tick();
            if (bus.done === 1'b1) begin
                ndone++;
                seen_sum = bus.sum;
                chk("ignore_cout", {31'd0, bus.cout}, 32'd0);
            end
        end
        bus.start = 1'b0;
        chk("ignore_done_count", ndone, 32'd1);
        chk("ignore_sum", {24'd0, seen_sum}, 32'h30);

        // reset mid-RUN aborts with no done pulse
        bus.start = 1'b1;
        bus.a = 8'h7F;
        bus.b = 8'h01;
        bus.cin = 1'b0;
        tick();
        bus.start = 1'b0;
        repeat (4) tick();
        chk("abort_busy_before", {31'd0, bus.busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        chk("abort_done", {31'd0, bus.done}, 32'd0);
        chk("abort_sum", {24'd0, bus.sum}, 32'd0);
        chk("abort_cout", {31'd0, bus.cout}, 32'd0);
        repeat (2) tick();
        #2 rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.done === 1'b1) ndone++;
        end
        chk("abort_no_done", ndone, 32'd0);
        run_op("post_abort_01_01", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0);

        // start held high: one result every 9 cycles, busy low only when done
        bus.start = 1'b1;
        bus.a = 8'h0F;
        bus.b = 8'h01;
        bus.cin = 1'b0;
        ndone_run = 0;
        last_done = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            chk("hold_busy_xor_done", {31'd0, bus.busy}, {31'd0, ~bus.done});
            if (bus.done === 1'b1) begin
                ndone_run++;
                chk("hold_sum", {24'd0, bus.sum}, 32'h10);
                chk("hold_cout", {31'd0, bus.cout}, 32'd0);
                if (last_done >= 0) chk("hold_period", i - last_done, 32'd9);
                last_done = i;
            end
        end
        chk("hold_done_count", ndone_run, 32'd4);
        bus.start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.done === 1'b1) break;
        end
        tick();
        chk("hold_final_idle_busy", {31'd0, bus.busy}, 32'd0);
        chk("hold_final_idle_done", {31'd0, bus.done}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
